multicycle_sequencer: RTL and testbench

//  Multi-cycle control FSM for the RISC-V core: sequences FETCH/DECODE/EXEC/MEM/WB over one shared

---
 rtl/multicycle_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM for the RISC-V core. It steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB over a shared memory port and counts retired instructions.
module multicycle_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int ALU_WIDTH  = 2,
    parameter int IMM_WIDTH  = 3,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] instr,
    input  logic                  EQ,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic                  MemWrite,
    output logic                  AddrSrc,
    output logic                  IRWrite,
    output logic                  PCWrite,
    output logic                  PCsrc,
    output logic                  RegWrite,
    output logic                  ResultSrc,
    output logic                  ALUsrc,
    output logic [ALU_WIDTH-1:0]  ALUctrl,
    output logic [IMM_WIDTH-1:0]  ImmSrc,
    output logic                  trap,
    output logic [CNT_WIDTH-1:0]  retired
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_e;

    localparam logic [ALU_WIDTH-1:0] ALU_ADD = '0;
    localparam logic [ALU_WIDTH-1:0] ALU_SUB = ALU_WIDTH'(1);
    localparam logic [IMM_WIDTH-1:0] IMM_I   = '0;
    localparam logic [IMM_WIDTH-1:0] IMM_S   = IMM_WIDTH'(1);
    localparam logic [IMM_WIDTH-1:0] IMM_B   = IMM_WIDTH'(2);

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] retired_q, retired_d;
    logic                 retire_en;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       is_addi, is_alu, is_lw, is_sw, is_bne, is_legal;

    logic                 mem_req_c, mem_write_c, addr_src_c, ir_write_c, pc_write_c;
    logic                 pc_src_c, reg_write_c, result_src_c, alu_src_c, trap_c;
    logic [ALU_WIDTH-1:0] alu_ctrl_c, alu_ctrl_dec;
    logic [IMM_WIDTH-1:0] imm_src_c, imm_src_dec;
    logic                 alu_src_dec;

    // Only opcode, funct3 and bit 30 steer control; the remaining fields belong to the datapath.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr[DATA_WIDTH-1:31], instr[29:15], instr[11:7]};

    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign is_addi  = (opcode == 7'b0010011) && (funct3 == 3'b000);
    assign is_alu   = (opcode == 7'b0110011) && (funct3 == 3'b000);
    assign is_lw    = (opcode == 7'b0000011) && (funct3 == 3'b010);
    assign is_sw    = (opcode == 7'b0100011) && (funct3 == 3'b010);
    assign is_bne   = (opcode == 7'b1100011) && (funct3 == 3'b001);
    assign is_legal = is_addi | is_alu | is_lw | is_sw | is_bne;

    // Operand controls are decoded straight from the IR and held through EXEC, MEM and WB.
    always_comb begin
        alu_src_dec  = 1'b0;
        alu_ctrl_dec = ALU_ADD;
        imm_src_dec  = IMM_I;
        if (is_addi || is_lw) begin
            alu_src_dec = 1'b1;
        end else if (is_sw) begin
            alu_src_dec = 1'b1;
            imm_src_dec = IMM_S;
        end else if (is_alu) begin
            alu_ctrl_dec = instr[30] ? ALU_SUB : ALU_ADD;
        end else if (is_bne) begin
            alu_ctrl_dec = ALU_SUB;
            imm_src_dec  = IMM_B;
        end
    end

    always_comb begin
        state_d      = state_q;
        retire_en    = 1'b0;
        mem_req_c    = 1'b0;
        mem_write_c  = 1'b0;
        addr_src_c   = 1'b0;
        ir_write_c   = 1'b0;
        pc_write_c   = 1'b0;
        pc_src_c     = 1'b0;
        reg_write_c  = 1'b0;
        result_src_c = 1'b0;
        alu_src_c    = 1'b0;
        alu_ctrl_c   = ALU_ADD;
        imm_src_c    = IMM_I;
        trap_c       = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req_c = 1'b1;
                if (mem_ready) begin
                    ir_write_c = 1'b1;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = is_legal ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                alu_src_c  = alu_src_dec;
                alu_ctrl_c = alu_ctrl_dec;
                imm_src_c  = imm_src_dec;
                if (is_bne) begin
                    pc_write_c = 1'b1;
                    pc_src_c   = ~EQ;
                    retire_en  = 1'b1;
                    state_d    = S_FETCH;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                alu_src_c   = alu_src_dec;
                alu_ctrl_c  = alu_ctrl_dec;
                imm_src_c   = imm_src_dec;
                mem_req_c   = 1'b1;
                addr_src_c  = 1'b1;
                mem_write_c = is_sw;
                if (mem_ready) begin
                    if (is_sw) begin
                        pc_write_c = 1'b1;
                        retire_en  = 1'b1;
                        state_d    = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                alu_src_c    = alu_src_dec;
                alu_ctrl_c   = alu_ctrl_dec;
                imm_src_c    = imm_src_dec;
                reg_write_c  = 1'b1;
                result_src_c = is_lw;
                pc_write_c   = 1'b1;
                retire_en    = 1'b1;
                state_d      = S_FETCH;
            end
            S_TRAP: begin
                trap_c = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    assign retired_d = retire_en ? retired_q + CNT_WIDTH'(1) : retired_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    // Outputs are forced low while reset is held, even though the state already reads FETCH.
    assign mem_req   = rst & mem_req_c;
    assign MemWrite  = rst & mem_write_c;
    assign AddrSrc   = rst & addr_src_c;
    assign IRWrite   = rst & ir_write_c;
    assign PCWrite   = rst & pc_write_c;
    assign PCsrc     = rst & pc_src_c;
    assign RegWrite  = rst & reg_write_c;
    assign ResultSrc = rst & result_src_c;
    assign ALUsrc    = rst & alu_src_c;
    assign ALUctrl   = rst ? alu_ctrl_c : '0;
    assign ImmSrc    = rst ? imm_src_c : '0;
    assign trap      = rst & trap_c;
    assign retired   = rst ? retired_q : '0;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: each instruction is expanded into a
// per-cycle list of expected control outputs, then replayed against the DUT.
module tb_multicycle_sequencer;

    localparam int CW = 4;

    localparam int K_ADDI = 0;
    localparam int K_ALU  = 1;
    localparam int K_LW   = 2;
    localparam int K_SW   = 3;
    localparam int K_BNE  = 4;
    localparam int K_ILL  = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [31:0]   instr = '0;
    logic          EQ = 1'b0;
    logic          mem_ready = 1'b0;
    logic          mem_req, MemWrite, AddrSrc, IRWrite, PCWrite, PCsrc;
    logic          RegWrite, ResultSrc, ALUsrc, trap;
    logic [1:0]    ALUctrl;
    logic [2:0]    ImmSrc;
    logic [CW-1:0] retired;

    always #5 clk = ~clk;

    multicycle_sequencer #(
        .DATA_WIDTH(32),
        .ALU_WIDTH (2),
        .IMM_WIDTH (3),
        .CNT_WIDTH (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .instr    (instr),
        .EQ       (EQ),
        .mem_ready(mem_ready),
        .mem_req  (mem_req),
        .MemWrite (MemWrite),
        .AddrSrc  (AddrSrc),
        .IRWrite  (IRWrite),
        .PCWrite  (PCWrite),
        .PCsrc    (PCsrc),
        .RegWrite (RegWrite),
        .ResultSrc(ResultSrc),
        .ALUsrc   (ALUsrc),
        .ALUctrl  (ALUctrl),
        .ImmSrc   (ImmSrc),
        .trap     (trap),
        .retired  (retired)
    );

    // One entry per clock cycle: inputs to drive and the outputs that cycle must show.
    typedef struct packed {
        logic [31:0]   ins;
        logic          mem_ready;
        logic          eq;
        logic          mem_req;
        logic          mem_write;
        logic          addr_src;
        logic          ir_write;
        logic          pc_write;
        logic          pc_src;
        logic          reg_write;
        logic          result_src;
        logic          alu_src;
        logic [1:0]    alu_ctrl;
        logic [2:0]    imm_src;
        logic          trap;
        logic [CW-1:0] retired;
        logic          chk_alu;
        logic          chk_imm;
    } cyc_t;

    cyc_t          exp_q[$];
    logic [CW-1:0] ret_m = '0;
    logic [31:0]   cur_instr = '0;
    int            checks = 0;
    int            errors = 0;

    function automatic int classify(input logic [31:0] ins);
        case ({ins[14:12], ins[6:0]})
            10'b000_0010011: return K_ADDI;
            10'b000_0110011: return K_ALU;
            10'b010_0000011: return K_LW;
            10'b010_0100011: return K_SW;
            10'b001_1100011: return K_BNE;
            default:         return K_ILL;
        endcase
    endfunction

    function automatic cyc_t blank();
        cyc_t c;
        c           = '0;
        c.ins       = cur_instr;
        c.retired   = ret_m;
        c.mem_ready = 1'($urandom_range(0, 1));
        c.eq        = 1'($urandom_range(0, 1));
        return c;
    endfunction

    function automatic cyc_t withAlu(input cyc_t cin, input int k, input logic [31:0] ins);
        cyc_t c;
        c         = cin;
        c.chk_alu = 1'b1;
        c.chk_imm = 1'b1;
        case (k)
            K_ADDI: begin c.alu_src = 1'b1; c.alu_ctrl = 2'd0; c.imm_src = 3'd0; end
            K_ALU:  begin c.alu_src = 1'b0; c.alu_ctrl = ins[30] ? 2'd1 : 2'd0; c.chk_imm = 1'b0; end
            K_LW:   begin c.alu_src = 1'b1; c.alu_ctrl = 2'd0; c.imm_src = 3'd0; end
            K_SW:   begin c.alu_src = 1'b1; c.alu_ctrl = 2'd0; c.imm_src = 3'd1; end
            default: begin c.alu_src = 1'b0; c.alu_ctrl = 2'd1; c.imm_src = 3'd2; end
        endcase
        return c;
    endfunction

    // Expands one instruction into its cycle list; fw/mw are memory wait cycles.
    task automatic buildInstr(input logic [31:0] ins, input int fw, input int mw,
                              input logic eq_v, output int ncyc);
        cyc_t c;
        int   k     = classify(ins);
        int   start = exp_q.size();
        cur_instr = ins;
        for (int i = 0; i < fw; i++) begin
            c = blank(); c.mem_req = 1'b1; c.mem_ready = 1'b0; exp_q.push_back(c);
        end
        c = blank(); c.mem_req = 1'b1; c.mem_ready = 1'b1; c.ir_write = 1'b1; exp_q.push_back(c);
        c = blank(); exp_q.push_back(c);
        if (k != K_ILL) begin
            c = withAlu(blank(), k, ins);
            if (k == K_BNE) begin
                c.eq = eq_v; c.pc_write = 1'b1; c.pc_src = ~eq_v;
                exp_q.push_back(c); ret_m++;
            end else begin
                exp_q.push_back(c);
                if (k == K_LW || k == K_SW) begin
                    for (int i = 0; i <= mw; i++) begin
                        c = withAlu(blank(), k, ins);
                        c.mem_req = 1'b1; c.addr_src = 1'b1; c.mem_write = (k == K_SW);
                        c.mem_ready = (i == mw);
                        if (k == K_SW && i == mw) c.pc_write = 1'b1;
                        exp_q.push_back(c);
                    end
                    if (k == K_SW) ret_m++;
                end
                if (k != K_SW) begin
                    c = withAlu(blank(), k, ins);
                    c.reg_write = 1'b1; c.result_src = (k == K_LW); c.pc_write = 1'b1;
                    exp_q.push_back(c); ret_m++;
                end
            end
        end
        ncyc = exp_q.size() - start;
    endtask

    task automatic addTrap(input int n);
        cyc_t c;
        for (int i = 0; i < n; i++) begin
            c = blank(); c.trap = 1'b1; exp_q.push_back(c);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic applyStimulus(input cyc_t c);
        instr     = c.ins;
        mem_ready = c.mem_ready;
        EQ        = c.eq;
    endtask

    task automatic checkOutput(input cyc_t c);
        chk("mem_req",   32'(mem_req),   32'(c.mem_req));
        chk("MemWrite",  32'(MemWrite),  32'(c.mem_write));
        chk("AddrSrc",   32'(AddrSrc),   32'(c.addr_src));
        chk("IRWrite",   32'(IRWrite),   32'(c.ir_write));
        chk("PCWrite",   32'(PCWrite),   32'(c.pc_write));
        chk("PCsrc",     32'(PCsrc),     32'(c.pc_src));
        chk("RegWrite",  32'(RegWrite),  32'(c.reg_write));
        chk("ResultSrc", 32'(ResultSrc), 32'(c.result_src));
        chk("trap",      32'(trap),      32'(c.trap));
        chk("retired",   32'(retired),   32'(c.retired));
        if (c.chk_alu) begin
            chk("ALUsrc",  32'(ALUsrc),  32'(c.alu_src));
            chk("ALUctrl", 32'(ALUctrl), 32'(c.alu_ctrl));
        end
        if (c.chk_imm) chk("ImmSrc", 32'(ImmSrc), 32'(c.imm_src));
    endtask

    task automatic checkZeros(input string tag);
        chk({tag, "_outs"}, 32'({mem_req, MemWrite, AddrSrc, IRWrite, PCWrite, PCsrc, RegWrite,
                                 ResultSrc, ALUsrc, ALUctrl, ImmSrc, trap}), 32'd0);
        chk({tag, "_retired"}, 32'(retired), 32'd0);
    endtask

    // Entered and left just after a rising edge; outputs are checked on the falling edge.
    task automatic runCycles(input int n);
        cyc_t c;
        for (int i = 0; i < n && exp_q.size() > 0; i++) begin
            c = exp_q.pop_front();
            applyStimulus(c);
            @(negedge clk);
            checkOutput(c);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic runQueue();
        runCycles(exp_q.size());
    endtask

    function automatic logic [31:0] randInstr(input int k);
        logic [31:0] r;
        r = $urandom;
        case (k)
            K_ADDI:  begin r[6:0] = 7'b0010011; r[14:12] = 3'b000; end
            K_ALU:   begin r[6:0] = 7'b0110011; r[14:12] = 3'b000; end
            K_LW:    begin r[6:0] = 7'b0000011; r[14:12] = 3'b010; end
            K_SW:    begin r[6:0] = 7'b0100011; r[14:12] = 3'b010; end
            default: begin r[6:0] = 7'b1100011; r[14:12] = 3'b001; end
        endcase
        return r;
    endfunction

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int          n;
        logic [31:0] r;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkZeros("in_reset");
        @(posedge clk);
        #1;
        rst = 1'b1;

        buildInstr(32'h00500093, 0, 0, 1'b0, n);
        chk("addi_cycles", 32'(n), 32'd4);
        runQueue();
        chk("retired_after_addi", 32'(retired), 32'd1);

        buildInstr(32'hFE209EE3, 0, 0, 1'b0, n);
        chk("bne_cycles", 32'(n), 32'd3);
        runQueue();
        buildInstr(32'hFE209EE3, 0, 0, 1'b1, n);
        runQueue();

        buildInstr(32'h0000A103, 3, 2, 1'b0, n);
        chk("lw_wait_cycles", 32'(n), 32'd10);
        runQueue();

        buildInstr(32'h0020A023, 0, 0, 1'b0, n);
        chk("sw_cycles", 32'(n), 32'd4);
        runQueue();
        chk("retired_after_directed", 32'(retired), 32'd5);

        for (int i = 0; i < 24; i++) begin
            buildInstr(randInstr($urandom_range(K_ADDI, K_BNE)), $urandom_range(0, 2),
                       $urandom_range(0, 2), 1'($urandom_range(0, 1)), n);
            runQueue();
        end

        // Abort a load while it waits in MEM.
        buildInstr(32'h0000A103, 1, 3, 1'b0, n);
        runCycles(5);
        applyStimulus(exp_q.pop_front());
        #2;
        rst = 1'b0;
        #1;
        checkZeros("mid_mem_reset");
        exp_q.delete();
        ret_m = '0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;

        for (int i = 0; i < 15; i++) begin
            buildInstr(32'h00500093, 0, 0, 1'b0, n);
            runQueue();
        end
        chk("retired_at_max", 32'(retired), 32'd15);
        buildInstr(32'h00500093, 0, 0, 1'b0, n);
        runQueue();
        chk("retired_wrapped", 32'(retired), 32'd0);

        buildInstr(32'hFFFFFFFF, 1, 0, 1'b0, n);
        addTrap(20);
        runQueue();
        rst = 1'b0;
        #1;
        checkZeros("trap_reset");
        ret_m = '0;
        @(posedge clk);
        #1;
        rst = 1'b1;

        buildInstr(32'h00500093, 0, 0, 1'b0, n);
        runQueue();
        chk("retired_after_trap_reset", 32'(retired), 32'd1);

        // A legal opcode with the wrong funct3 must trap as well.
        r = randInstr(K_LW);
        r[14:12] = 3'b001;
        buildInstr(r, 0, 0, 1'b0, n);
        addTrap(4);
        runQueue();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
